// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg : shared state encodings and constants for the loader
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } load_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// ------------------------------------------------------------------
// uart_rx : 8N1 receiver with mid-bit sampling and glitch rejection
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic             sync1, sync2, sync_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign byte_data = shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RX_IDLE;
      sync1           <= 1'b1;
      sync2           <= 1'b1;
      sync_prev       <= 1'b1;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      sync1           <= rxd;
      sync2           <= sync1;
      sync_prev       <= sync2;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (sync_prev && !sync2) state <= RX_START;
        end
        RX_START: begin
          // a line that is high again at mid-start was only a glitch
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync2) byte_valid      <= 1'b1;
            else       frame_err_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_prog_loader.sv
// ------------------------------------------------------------------
// uart_prog_loader : packs UART bytes into words and fills imem
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CELL_NUMBERS = 64,
  parameter int ADDR_W       = (CELL_NUMBERS > 1) ? $clog2(CELL_NUMBERS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic              cpu_hold,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_NUMBERS - 1);
  localparam logic [1:0]        LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err_pulse;
  load_state_t       state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [23:0]       word_buf;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk            (clk),
    .rst            (rst),
    .rxd            (uart_rxd),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .frame_err_pulse(frame_err_pulse)
  );

  assign cpu_hold = ~load_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (frame_err_pulse) frame_err <= 1'b1;
      case (state)
        LOAD: begin
          if (imem_we && imem_addr == LAST_ADDR) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_LANE) begin
              imem_we    <= 1'b1;
              imem_wdata <= {byte_data, word_buf};
              imem_addr  <= word_cnt;
              // the last address is never advanced past, so word_cnt cannot wrap
              if (word_cnt != LAST_ADDR) word_cnt <= word_cnt + 1'b1;
            end else begin
              word_buf[{byte_cnt, 3'b000} +: 8] <= byte_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
